follow_led_bank: RTL

- Multi-channel activity/follow LED driver.
- Each channel synchronises an asynchronous activity input and stretches its rising edges into a visible LED pulse using a saturating hold counter.
- The output is shaped per channel by a runtime mode: off, follow, blink or force-on.
- Sits between status/activity sources (link, DMA, RAM access strobes) and board LED pins.
- Replaces single-channel, wrap-prone follow LEDs.

---
 rtl/follow_led_pkg.sv | 29 ++
 rtl/follow_led_chan.sv | 84 ++++++++
 rtl/follow_led_bank.sv | 95 +++++++++
 3 files changed

// File: rtl/follow_led_pkg.sv
// Shared types and helpers for the follow LED bank.
// Holds mode encodings and the saturating-add helper.
package follow_led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_FOLLOW = 2'b01,
    MODE_BLINK  = 2'b10,
    MODE_ON     = 2'b11
  } mode_e;

  localparam int SAT_W = 32;

  // Sum is formed one bit wider so the carry is never lost
  // before the clamp against max.
  function automatic logic [SAT_W-1:0] sat_add(
    input logic [SAT_W-1:0] a,
    input logic [SAT_W-1:0] b,
    input logic [SAT_W-1:0] max
  );
    logic [SAT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, max}) begin
      return max;
    end
    return sum[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/follow_led_chan.sv
// One follow LED channel: 3-flop synchroniser, rising-edge detect,
// saturating hold counter and registered mode mux.
// Ports: clk/rst (sync, active-high), sig_in (async), mode[1:0],
//   blink_phase, pwm_gate (FOLLOW_LED_PWM_EN only), led, cnt_nz_next.
module follow_led_chan
  import follow_led_pkg::*;
#(
  parameter int CNT_W       = 24,
  parameter int FOLLOW_CONS = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sig_in,
  input  logic [1:0] mode,
  input  logic       blink_phase,
`ifdef FOLLOW_LED_PWM_EN
  input  logic       pwm_gate,
`endif
  output logic       led,
  output logic       cnt_nz_next
);

  localparam logic [SAT_W-1:0] CNT_MAX = SAT_W'({CNT_W{1'b1}});
  localparam logic [SAT_W-1:0] INC_FC  = SAT_W'(FOLLOW_CONS);
  localparam logic [SAT_W-1:0] INC_ONE = SAT_W'(1);

  logic             s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             led_q, led_d;
  logic             rise;
  logic             cnt_nz;

  assign rise   = s2_q & ~s3_q;
  assign cnt_nz = (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (mode == MODE_OFF) begin
      cnt_d = '0;
    end else if (rise) begin
      cnt_d = CNT_W'(sat_add(SAT_W'(cnt_q), INC_FC, CNT_MAX));
    end else if (s3_q) begin
      cnt_d = CNT_W'(sat_add(SAT_W'(cnt_q), INC_ONE, CNT_MAX));
    end else if (cnt_nz) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // LED reflects the counter before this edge's update, giving the
  // extra cycle of latency after the counter loads.
  always_comb begin
    led_d = 1'b0;
    unique case (mode)
      MODE_OFF:    led_d = 1'b0;
      MODE_FOLLOW: led_d = cnt_nz;
      MODE_BLINK:  led_d = cnt_nz & ~blink_phase;
      MODE_ON:     led_d = 1'b1;
      default:     led_d = 1'b0;
    endcase
`ifdef FOLLOW_LED_PWM_EN
    led_d = led_d & pwm_gate;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      s3_q  <= 1'b0;
      cnt_q <= '0;
      led_q <= 1'b0;
    end else begin
      s1_q  <= sig_in;
      s2_q  <= s1_q;
      s3_q  <= s2_q;
      cnt_q <= cnt_d;
      led_q <= led_d;
    end
  end

  assign led         = led_q;
  assign cnt_nz_next = (cnt_d != '0);

endmodule

// File: rtl/follow_led_bank.sv
// Multi-channel activity/follow LED driver with per-channel modes.
// Ports: io_clk, io_rst_ram (sync, active-high), sig_in[CHANNELS],
//   mode[2*CHANNELS], pwm_duty[PWM_W], follow_light[CHANNELS],
//   any_active. Optional PWM dimming: define FOLLOW_LED_PWM_EN.
module follow_led_bank
  import follow_led_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int CNT_W       = 24,
  parameter int FOLLOW_CONS = 500,
  parameter int BLINK_DIV   = 5000000,
  parameter int PWM_W       = 4
) (
  input  logic                  io_clk,
  input  logic                  io_rst_ram,
  input  logic [CHANNELS-1:0]   sig_in,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [PWM_W-1:0]      pwm_duty,
  output logic [CHANNELS-1:0]   follow_light,
  output logic                  any_active
);

  localparam int PRE_W =
    (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(BLINK_DIV - 1);

  logic [PRE_W-1:0]    presc_q, presc_d;
  logic                blink_phase_q, blink_phase_d;
  logic                any_active_q, any_active_d;
  logic [CHANNELS-1:0] cnt_nz_next;

  // Free-running shared blink timebase; phase flips on each wrap.
  always_comb begin
    presc_d       = presc_q + PRE_W'(1);
    blink_phase_d = blink_phase_q;
    if (presc_q == PRE_LAST) begin
      presc_d       = '0;
      blink_phase_d = ~blink_phase_q;
    end
  end

`ifdef FOLLOW_LED_PWM_EN
  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic             pwm_gate;

  assign pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
  assign pwm_gate  = (pwm_cnt_q < pwm_duty);

  always_ff @(posedge io_clk) begin
    if (io_rst_ram) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
    end
  end
`else
  logic unused_pwm_duty;
  assign unused_pwm_duty = ^pwm_duty;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    follow_led_chan #(
      .CNT_W       (CNT_W),
      .FOLLOW_CONS (FOLLOW_CONS)
    ) u_chan (
      .clk         (io_clk),
      .rst         (io_rst_ram),
      .sig_in      (sig_in[i]),
      .mode        (mode[2*i+1:2*i]),
      .blink_phase (blink_phase_q),
`ifdef FOLLOW_LED_PWM_EN
      .pwm_gate    (pwm_gate),
`endif
      .led         (follow_light[i]),
      .cnt_nz_next (cnt_nz_next[i])
    );
  end

  assign any_active_d = |cnt_nz_next;

  always_ff @(posedge io_clk) begin
    if (io_rst_ram) begin
      presc_q       <= '0;
      blink_phase_q <= 1'b0;
      any_active_q  <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      blink_phase_q <= blink_phase_d;
      any_active_q  <= any_active_d;
    end
  end

  assign any_active = any_active_q;

endmodule
